hub75_pixel_writer: RTL

HUB75_PIXEL_WRITER -- requirements
Module: hub75_pixel_writer

---
 rtl/hub75_pixel_writer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/hub75_pixel_writer.sv
// hub75_pixel_writer: turns a {R,G,B} pixel stream framed by SOF/EOL into
// framebuffer writes at row*hpixel_p+col, with framing-error detection.
// Optional build macro HUB75_GAMMA_EN: squares each channel ((c*c)>>bpp_p)
// through one extra pipeline stage; address, strobe and frame_done follow.
module hub75_pixel_writer #(
   parameter int hpixel_p = 64,
   parameter int vpixel_p = 64,
   parameter int bpp_p    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_enable,
   input  logic                      i_pix_valid,
   output logic                      o_pix_ready,
   input  logic [3*bpp_p-1:0]        i_pix_data,
   input  logic                      i_pix_sof,
   input  logic                      i_pix_eol,
   output logic [$clog2(hpixel_p*vpixel_p)-1:0] o_wr_addr,
   output logic [3*bpp_p-1:0]        o_wr_data,
   output logic                      o_wr_en,
   output logic                      o_frame_done,
   output logic                      o_sync_err
);
   localparam int addr_width_p = $clog2(hpixel_p*vpixel_p);
   localparam int col_w = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
   localparam int row_w = (vpixel_p > 1) ? $clog2(vpixel_p) : 1;
   localparam int dw    = 3*bpp_p;
   localparam logic [col_w-1:0] col_last = col_w'(hpixel_p-1);
   localparam logic [row_w-1:0] row_last = row_w'(vpixel_p-1);

   typedef enum logic {WAIT_SOF, ACTIVE} state_t;

   state_t            state, state_nx;
   logic [col_w-1:0]  col, col_nx, cur_col;
   logic [row_w-1:0]  row, row_nx, cur_row;
   logic              acc, line_end;
   logic              wr_nx, done_nx, err_set, err_clr;
   logic [addr_width_p-1:0] addr_nx;

   // stage-1 registers (acceptance -> write)
   logic                    s1_wr, s1_done;
   logic [addr_width_p-1:0] s1_addr;
   logic [dw-1:0]           s1_data;
   logic                    last_done;

   // no backpressure beyond the enable gate
   assign o_pix_ready = i_enable;
   assign acc         = i_pix_valid & i_enable;

   // FSM state, position counters and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= WAIT_SOF;
         col        <= '0;
         row        <= '0;
         o_sync_err <= 1'b0;
      end else begin
         state <= state_nx;
         col   <= col_nx;
         row   <= row_nx;
         if (err_set)      o_sync_err <= 1'b1;
         else if (err_clr) o_sync_err <= 1'b0;
      end
   end

   // next-state: an SOF beat always lands at (0,0); the line-end rules then
   // apply to whatever position the beat was written at
   always_comb begin
      state_nx = state;
      col_nx   = col;
      row_nx   = row;
      cur_col  = col;
      cur_row  = row;
      wr_nx    = 1'b0;
      done_nx  = 1'b0;
      err_set  = 1'b0;
      err_clr  = 1'b0;
      line_end = 1'b0;
      if (acc && (i_pix_sof || state == ACTIVE)) begin
         wr_nx = 1'b1;
         if (i_pix_sof) begin
            cur_col = '0;
            cur_row = '0;
            if (state == ACTIVE) err_set = 1'b1;
            else                 err_clr = 1'b1;
         end
         line_end = i_pix_eol || (cur_col == col_last);
         // short line (EOL early) or long line (no EOL at last column)
         if (i_pix_eol != (cur_col == col_last)) err_set = 1'b1;
         if (line_end) begin
            col_nx = '0;
            if (cur_row == row_last) begin
               row_nx   = '0;
               state_nx = WAIT_SOF;
               done_nx  = 1'b1;
            end else begin
               row_nx   = cur_row + 1'b1;
               state_nx = ACTIVE;
            end
         end else begin
            col_nx   = cur_col + 1'b1;
            row_nx   = cur_row;
            state_nx = ACTIVE;
         end
      end
      addr_nx = addr_width_p'(int'(cur_row)*hpixel_p + int'(cur_col));
   end

   // register the write one cycle after acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_wr   <= 1'b0;
         s1_done <= 1'b0;
         s1_addr <= '0;
         s1_data <= '0;
      end else begin
         s1_wr   <= wr_nx;
         s1_done <= done_nx;
         if (wr_nx) begin
            s1_addr <= addr_nx;
            s1_data <= i_pix_data;
         end
      end
   end

`ifdef HUB75_GAMMA_EN
   logic [dw-1:0]           gam;
   logic                    s2_wr, s2_done;
   logic [addr_width_p-1:0] s2_addr;
   logic [dw-1:0]           s2_data;

   // per-channel square in full 2*bpp_p width, keep the upper half
   for (genvar ch = 0; ch < 3; ch++) begin : g_gamma
      logic [2*bpp_p-1:0] prod;
      assign prod = s1_data[ch*bpp_p +: bpp_p] * s1_data[ch*bpp_p +: bpp_p];
      assign gam[ch*bpp_p +: bpp_p] = prod[2*bpp_p-1:bpp_p];
   end

   // second stage keeps address/strobe aligned with the squared data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_wr   <= 1'b0;
         s2_done <= 1'b0;
         s2_addr <= '0;
         s2_data <= '0;
      end else begin
         s2_wr   <= s1_wr;
         s2_done <= s1_done;
         if (s1_wr) begin
            s2_addr <= s1_addr;
            s2_data <= gam;
         end
      end
   end

   assign o_wr_en   = s2_wr;
   assign o_wr_addr = s2_addr;
   assign o_wr_data = s2_data;
   assign last_done = s2_done;
`else
   assign o_wr_en   = s1_wr;
   assign o_wr_addr = s1_addr;
   assign o_wr_data = s1_data;
   assign last_done = s1_done;
`endif

   // frame_done lands the cycle after the final write strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) o_frame_done <= 1'b0;
      else        o_frame_done <= last_done;
   end
endmodule
